// File: rtl/jpeg_byte_stuffer.sv
// JPEG final bitstream stage: escapes 0xFF bytes with a trailing 0x00, pads and
// terminates the last word (optional EOI), and repacks bytes into 32-bit words.
module jpeg_byte_stuffer #(
    parameter int unsigned BUF_BYTES  = 32,
    parameter bit          APPEND_EOI = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] jpeg_in,
    input  logic        jpeg_in_valid,
    input  logic [4:0]  orc_in,
    input  logic        eof_in,
    output logic [31:0] jpeg_out,
    output logic        out_valid,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic        overflow,
    output logic        proto_err
);

    localparam int unsigned CW = $clog2(BUF_BYTES + 1);
    localparam int unsigned BW = BUF_BYTES * 8;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e state_q, state_d;

    // Byte FIFO held as a left-aligned vector; bytes at and beyond cnt are always zero.
    logic [BW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] jpeg_out_q;
    logic        out_valid_q;
    logic [2:0]  out_bytes_q;
    logic        out_last_q;
    logic        overflow_q;
    logic        proto_err_q;

    logic [5:0]    n_bits;
    logic [2:0]    k_bytes;
    logic [31:0]   padded;
    logic [31:0]   cur;
    logic [79:0]   exp_acc;
    logic [3:0]    exp_len;
    logic [6:0]    exp_sh;
    logic [79:0]   exp_left;
    logic [BW-1:0] exp_wide;

    logic [2:0]    pop_n;
    logic [CW-1:0] cnt_ap;
    logic [CW:0]   need;
    logic          fits;
    logic          in_run;
    logic          accept;
    logic          ovf_set;
    logic          perr_set;
    logic          last_pop;
    logic [31:0]   pop_word;

    // Expansion of the incoming word, right-aligned while built, then left-aligned.
    always_comb begin
        n_bits  = (orc_in == 5'd0) ? 6'd32 : {1'b0, orc_in};
        padded  = eof_in ? (jpeg_in | (32'hFFFF_FFFF >> n_bits)) : jpeg_in;
        k_bytes = eof_in ? 3'((n_bits + 6'd7) >> 3) : 3'd4;
        cur     = padded;
        exp_acc = '0;
        exp_len = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (3'(b) < k_bytes) begin
                exp_acc = {exp_acc[71:0], cur[31:24]};
                exp_len = exp_len + 4'd1;
                if (cur[31:24] == 8'hFF) begin
                    exp_acc = {exp_acc[71:0], 8'h00};
                    exp_len = exp_len + 4'd1;
                end
            end
            cur = {cur[23:0], 8'h00};
        end
        if (eof_in && APPEND_EOI) begin
            exp_acc = {exp_acc[63:0], 8'hFF, 8'hD9};
            exp_len = exp_len + 4'd2;
        end
        exp_sh   = {4'd10 - exp_len, 3'b000};
        exp_left = exp_acc << exp_sh;
        exp_wide = {exp_left, {(BW - 80){1'b0}}};
    end

    // Pop happens before append within the same edge.
    always_comb begin
        pop_n = '0;
        if (enable) begin
            if (cnt_q >= CW'(4)) begin
                pop_n = 3'd4;
            end else if (state_q == ST_FLUSH && cnt_q != '0) begin
                pop_n = cnt_q[2:0];
            end
        end
        cnt_ap   = cnt_q - CW'(pop_n);
        need     = {1'b0, cnt_ap} + (CW + 1)'(exp_len);
        fits     = need <= (CW + 1)'(BUF_BYTES);
        in_run   = enable && (state_q == ST_RUN) && jpeg_in_valid;
        accept   = in_run && fits;
        ovf_set  = in_run && !fits;
        perr_set = enable && (state_q == ST_FLUSH) && jpeg_in_valid;
        last_pop = (state_q == ST_FLUSH) && (pop_n != '0) && (cnt_ap == '0);
        pop_word = buf_q[BW-1 -: 32] & ~(32'hFFFF_FFFF >> {pop_n, 3'b000});
        buf_d    = (buf_q << {pop_n, 3'b000})
                 | (accept ? (exp_wide >> {cnt_ap, 3'b000}) : '0);
        cnt_d    = accept ? (cnt_ap + CW'(exp_len)) : cnt_ap;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (accept && eof_in) state_d = ST_FLUSH;
            ST_FLUSH: if (enable && cnt_ap == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            jpeg_out_q  <= '0;
            out_valid_q <= 1'b0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else if (enable) begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (pop_n != '0);
            if (pop_n != '0) begin
                jpeg_out_q  <= pop_word;
                out_bytes_q <= pop_n;
                out_last_q  <= last_pop;
            end else begin
                out_last_q  <= 1'b0;
            end
            overflow_q  <= overflow_q | ovf_set;
            proto_err_q <= proto_err_q | perr_set;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign jpeg_out  = jpeg_out_q;
    assign out_valid = out_valid_q;
    assign out_bytes = out_bytes_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Bench for jpeg_byte_stuffer: queue-based byte model checked every cycle,
// directed scenarios pinned by literal words, then randomized traffic.
module tb_jpeg_byte_stuffer;

    localparam int BUF = 32;
    localparam bit EOI = 1'b1;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] jpeg_in;
    logic        jpeg_in_valid;
    logic [4:0]  orc_in;
    logic        eof_in;
    logic [31:0] jpeg_out;
    logic        out_valid;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic        overflow;
    logic        proto_err;

    jpeg_byte_stuffer #(.BUF_BYTES(BUF), .APPEND_EOI(EOI)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .jpeg_in(jpeg_in), .jpeg_in_valid(jpeg_in_valid),
        .orc_in(orc_in), .eof_in(eof_in),
        .jpeg_out(jpeg_out), .out_valid(out_valid), .out_bytes(out_bytes),
        .out_last(out_last), .overflow(overflow), .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]  mq[$];
    bit          m_flush;
    bit          e_valid, e_last, e_ovf, e_perr;
    logic [31:0] e_out;
    int          e_bytes;
    bit          was_rst;
    logic [31:0] mw[$];
    int          mb[$];
    int          ml[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit v, input bit eof,
                              input logic [4:0] orc, input logic [31:0] w);
        int pn;
        int n;
        int k;
        bit flush_edge;
        logic [7:0] b;
        logic [7:0] ex[$];
        logic [31:0] word;
        was_rst = r;
        if (r) begin
            mq.delete();
            m_flush = 0; e_valid = 0; e_last = 0; e_ovf = 0; e_perr = 0;
            e_out = 0; e_bytes = 0;
            return;
        end
        if (!en) begin
            e_valid = 0;
            return;
        end
        pn = 0;
        if (mq.size() >= 4) pn = 4;
        else if (m_flush && mq.size() > 0) pn = mq.size();
        flush_edge = m_flush;
        e_valid = 0;
        if (pn > 0) begin
            word = 0;
            for (int i = 0; i < pn; i++) word |= 32'(mq.pop_front()) << (24 - 8 * i);
            e_out = word;
            e_bytes = pn;
            e_last = m_flush && (mq.size() == 0);
            e_valid = 1;
            mw.push_back(e_out); mb.push_back(e_bytes); ml.push_back(int'(e_last));
            if (e_last) m_flush = 0;
        end else begin
            e_last = 0;
        end
        if (v) begin
            if (flush_edge) begin
                e_perr = 1;
            end else begin
                n = eof ? ((orc == 0) ? 32 : int'(orc)) : 32;
                k = (n + 7) / 8;
                for (int i = 0; i < k; i++) begin
                    b = 8'((w >> (24 - 8 * i)) & 32'hFF);
                    if (i == k - 1) b = b | 8'((1 << (8 * k - n)) - 1);
                    ex.push_back(b);
                    if (b == 8'hFF) ex.push_back(8'h00);
                end
                if (eof && EOI) begin
                    ex.push_back(8'hFF);
                    ex.push_back(8'hD9);
                end
                if (mq.size() + ex.size() > BUF) begin
                    e_ovf = 1;
                end else begin
                    foreach (ex[i]) mq.push_back(ex[i]);
                    if (eof) m_flush = 1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("proto_err", 32'(proto_err), 32'(e_perr));
        if (e_valid || was_rst) begin
            chk("jpeg_out", jpeg_out, e_out);
            chk("out_bytes", 32'(out_bytes), 32'(e_bytes));
            chk("out_last", 32'(out_last), 32'(e_last));
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit v, input bit eof,
                       input logic [4:0] orc, input logic [31:0] w);
        rst = r; enable = en; jpeg_in_valid = v; eof_in = eof; orc_in = orc; jpeg_in = w;
        @(posedge clk);
        model_step(r, en, v, eof, orc, w);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 5'd0, 32'h0);
    endtask

    task automatic clr_log();
        mw.delete(); mb.delete(); ml.delete();
    endtask

    initial begin
        logic [31:0] rw;
        logic [7:0]  rb;
        bit          rv, re, ren, rr;

        // Reset
        cyc(1, 1, 0, 0, 5'd0, 32'h0);
        cyc(1, 1, 0, 0, 5'd0, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_out", jpeg_out, 32'h0);
        chk("rst_bytes", 32'(out_bytes), 32'h0);

        // Plain word
        clr_log();
        cyc(0, 1, 1, 0, 5'd0, 32'h1234_5678);
        idle(3);
        chk("plain_n", mw.size(), 1);
        chk("plain_w", mw[0], 32'h1234_5678);
        chk("plain_b", mb[0], 4);
        chk("plain_q", mq.size(), 0);

        // EOF with pad and EOI
        clr_log();
        cyc(0, 1, 1, 1, 5'd10, 32'hABC0_0000);
        idle(4);
        chk("eof_n", mw.size(), 2);
        chk("eof_w0", mw[0], 32'hABFF_00FF);
        chk("eof_b0", mb[0], 4);
        chk("eof_l0", ml[0], 0);
        chk("eof_w1", mw[1], 32'hD900_0000);
        chk("eof_b1", mb[1], 1);
        chk("eof_l1", ml[1], 1);
        chk("eof_run", 32'(m_flush), 32'h0);

        // All-0xFF burst
        clr_log();
        cyc(0, 1, 1, 0, 5'd0, 32'hFFFF_FFFF);
        cyc(0, 1, 1, 0, 5'd0, 32'hFFFF_FFFF);
        idle(5);
        chk("ff_n", mw.size(), 4);
        for (int i = 0; i < 4; i++) chk("ff_w", mw[i], 32'hFF00_FF00);
        chk("ff_ovf", 32'(overflow), 32'h0);

        // Stuffing with carry-over
        clr_log();
        cyc(0, 1, 1, 0, 5'd0, 32'hFF00_FFAB);
        cyc(0, 1, 1, 0, 5'd0, 32'h1122_3344);
        idle(3);
        chk("stf_n", mw.size(), 2);
        chk("stf_w0", mw[0], 32'hFF00_00FF);
        chk("stf_w1", mw[1], 32'h00AB_1122);
        chk("stf_q", mq.size(), 2);
        cyc(1, 1, 0, 0, 5'd0, 32'h0);

        // Overflow on the 8th back-to-back 0xFF word
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 1, 0, 5'd0, 32'hFFFF_FFFF);
            if (i == 7) chk("ovf_7", 32'(overflow), 32'h0);
            if (i == 8) chk("ovf_8", 32'(overflow), 32'h1);
        end
        idle(10);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Valid word during FLUSH
        cyc(0, 1, 1, 1, 5'd10, 32'hABC0_0000);
        cyc(0, 1, 1, 0, 5'd0, 32'h1234_5678);
        chk("perr", 32'(proto_err), 32'h1);
        idle(4);

        // Reset mid-FLUSH
        cyc(1, 1, 0, 0, 5'd0, 32'h0);
        cyc(0, 1, 1, 1, 5'd10, 32'hABC0_0000);
        cyc(1, 1, 0, 0, 5'd0, 32'h0);
        chk("rmf_valid", 32'(out_valid), 32'h0);
        chk("rmf_last", 32'(out_last), 32'h0);
        chk("rmf_out", jpeg_out, 32'h0);
        chk("rmf_ovf", 32'(overflow), 32'h0);
        chk("rmf_perr", 32'(proto_err), 32'h0);
        clr_log();
        cyc(0, 1, 1, 0, 5'd0, 32'h1234_5678);
        idle(3);
        chk("rmf_n", mw.size(), 1);
        chk("rmf_w", mw[0], 32'h1234_5678);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rw = 0;
            for (int i = 0; i < 4; i++) begin
                rb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                rw = {rw[23:0], rb};
            end
            rv  = ($urandom_range(0, 9) < 6);
            re  = rv && ($urandom_range(0, 19) == 0);
            ren = ($urandom_range(0, 9) != 0);
            rr  = ($urandom_range(0, 299) == 0);
            cyc(rr, ren, rv, re, 5'($urandom_range(0, 31)), rw);
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_byte_stuffer.md
# jpeg_byte_stuffer

Final bitstream stage of the JPEG encoder, directly downstream of `fifo_out`. It takes packed 32-bit Huffman words and inserts a 0x00 byte after every 0xFF byte, as JPEG marker escaping requires. At end of image it pads the last partial byte with 1s, optionally appends the EOI marker 0xFFD9, and repacks the result into 32-bit output words. The output is a byte-exact, stuffed stream ready for the file writer.

## Interface

Parameters:
- `BUF_BYTES`, 32: internal byte-buffer capacity; must be ≥ 12.
- `APPEND_EOI`, 1: when 1, the unstuffed marker bytes 0xFF, 0xD9 follow the final data byte.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  master enable; when low, all state holds and `out_valid`=0.
- `jpeg_in`  in  32  packed bitstream word; bits [31:24] are the first byte.
- `jpeg_in_valid`  in  1  `jpeg_in` valid this cycle (driven by `fifo_out` `data_ready`).
- `orc_in`  in  5  valid-bit count of the final word; sampled only with `eof_in`; 0 means 32.
- `eof_in`  in  1  qualifies `jpeg_in_valid`; marks the final word of the image.
- `jpeg_out`  out  32  stuffed output word, left-aligned; unused low bytes are 0.
- `out_valid`  out  1  `jpeg_out` valid; one-cycle pulse per word.
- `out_bytes`  out  3  valid bytes in `jpeg_out` (1..4); equals 4 unless `out_last`.
- `out_last`  out  1  final word of the image.
- `overflow`  out  1  sticky; input bytes were dropped because the buffer was full.
- `proto_err`  out  1  sticky; `jpeg_in_valid` was seen while in FLUSH.

## Operation

- Byte buffer: `BUF_BYTES`-entry FIFO of bytes with a count `cnt` of width $clog2(BUF_BYTES+1).
- Expansion of an accepted word: take bytes B3..B0 (B3 = [31:24]) in that order. Each byte is appended, followed by 0x00 if it equals 0xFF. One word therefore appends 4..8 bytes.
- Final word (`eof_in`=1):
  - n = `orc_in` (0 → 32) valid bits; k = ceil(n/8) bytes are used.
  - Bits below position 32−n inside byte k−1 are forced to 1 (JPEG pad).
  - Bytes beyond k are discarded.
  - Stuffing applies to the padded bytes.
  - If `APPEND_EOI`=1, 0xFF, 0xD9 are then appended without stuffing.
- Per edge, when `enable`=1, order of operations:
  1. Pop: if `cnt` ≥ 4, or (FLUSH and `cnt` > 0), pop min(`cnt`, 4) bytes into `jpeg_out`.
  2. Append: append the expansion of a word sampled this edge.
- Overflow: if `cnt` after pop + expansion size > `BUF_BYTES`, the whole word is dropped and `overflow` is set. The buffer is otherwise unchanged.
- State machine:
  - RUN (reset state): accept words. An accepted word with `eof_in`=1 → FLUSH.
  - FLUSH: input ignored; any `jpeg_in_valid` sets `proto_err`. Pops up to 4 bytes per edge. The pop that empties the buffer drives `out_last`=1 and `out_bytes`=bytes popped, then → RUN.
  - An eof word that expands to 0 bytes (only possible with `APPEND_EOI`=0) cannot occur, since k ≥ 1.
- `enable`=0: no pop, no append, no state change, input not sampled. Outputs other than `out_valid` hold.

## Timing

- Reset values: `jpeg_out`=0, `out_valid`=0, `out_bytes`=0, `out_last`=0, `overflow`=0, `proto_err`=0, `cnt`=0, state RUN.
- Reset takes effect at the first edge with `rst`=1, including mid-FLUSH. Buffer contents are discarded.
- Latency: a word sampled at edge E (empty buffer) produces `out_valid`=1 in the cycle after edge E+1.
- Throughput: one output word per cycle; one input word per cycle. Sustained 0xFF-heavy input exceeds throughput, and that is reported via `overflow`.
- Outputs are registered. `out_valid`, `out_last` and `out_bytes` change only on edges.
- Simultaneous pop and append in one edge is legal; `cnt` = `cnt` − popped + appended.

## Test plan

- Plain word: 0x12345678 valid at edge E → `jpeg_out`=0x12345678, `out_bytes`=4 after edge E+1; `cnt`=0.
- Stuffing with carry-over: 0xFF00FFAB then 0x11223344 → outputs 0xFF0000FF, then 0x00AB1122; 2 bytes (0x33, 0x44) remain.
- All-0xFF burst: 0xFFFFFFFF ×2 back-to-back → four words 0xFF00FF00 on consecutive cycles; `overflow`=0.
- EOF with pad and EOI: 0xABC00000, `orc_in`=10, `eof_in`=1 → 0xABFF00FF (`out_bytes`=4), then 0xD9000000 (`out_bytes`=1, `out_last`=1); state returns to RUN.
- Overflow and protocol error:
  - 10 back-to-back 0xFFFFFFFF → `overflow` rises on the 8th word (net +4 bytes per cycle) and stays high until `rst`.
  - A valid word during FLUSH → `proto_err`=1.
- Reset mid-FLUSH: assert `rst` one cycle after the eof word → next cycle all outputs 0, no `out_last`; a following plain word behaves as in the first scenario.
